spart_rx_core: RTL and testbench
================================

Name: spart_rx_core

Overview:
- Receive half of the SPART serial port: a programmable baud-rate generator plus an 8N1 UART receiver in one block.
- The generator divides the system clock into a 16x-oversample tick (rxEnable) and a 1x bit tick (txEnable); the transmitter elsewhere consumes txEnable.
- The receiver oversamples RxD, assembles a byte and presents it on rec_buff, with the RDA flag cleared by a processor-side read.

Parameters:
- RESET_DIVISOR, 16'd650, divisor after reset (9600 baud x16 at 100 MHz clk).
- DATA_BITS, 8, data bits per frame (fixed 8N1; not intended to be changed).

Ports:
- clk  input  1  system clock, 100 MHz nominal.
- rst  input  1  reset, asynchronous, active-high.
- RxD  input  1  serial receive line, idle high.
- IOCS  input  1  chip select from processor bus.
- IORW  input  1  1 = read, 0 = write.
- IOADDR  input  2  register address: 00 = rx data, 10 = divisor low byte, 11 = divisor high byte.
- baud_load  input  1  divisor write strobe; qualifies IOADDR 10/11.
- baud_gen  input  8  divisor byte being written.
- rec_buff  output  8  last received byte.
- RDA  output  1  receive data available.
- rxEnable  output  1  one-cycle 16x oversample tick.
- txEnable  output  1  one-cycle bit-rate tick.

Behaviour:
- Reset (async, rst=1):
  - divisor = RESET_DIVISOR; down-counter = divisor; tick counter = 0.
  - rxEnable = 0, txEnable = 0, rec_buff = 8'h00, RDA = 0.
  - FSM = IDLE; RxD synchronizer flops = 1.
- Divisor writes (baud_load=1, on clk edge):
  - IOADDR=10 writes divisor[7:0]; IOADDR=11 writes divisor[15:8].
  - Each write reloads the down-counter with the new full divisor value.
  - IOADDR 00/01 with baud_load is ignored by the generator.
- Baud generator:
  - The 16-bit down-counter decrements every clk.
  - At 0 it asserts rxEnable for one cycle and reloads the divisor, giving rxEnable period = divisor+1 clocks (650 -> 651 clocks = 6.51 us).
  - Divisor 0 makes rxEnable high every cycle.
  - A 4-bit counter counts rxEnable pulses; txEnable pulses in the same cycle as every 16th rxEnable (period 16*(divisor+1) = 10416 clocks at 650).
- RxD input: 2-flop synchronizer; the FSM uses the synchronized value, adding 2 cycles of latency.
- Receiver FSM (all state changes only on cycles with rxEnable=1; 4-bit tick count, 3-bit bit index, 8-bit shift register):
  - IDLE: RxD=0 -> START, tick=0.
  - START: tick increments. When tick reaches 7 (mid start bit): RxD=0 -> DATA with tick=0, bit=0; RxD=1 -> IDLE (glitch rejected).
  - DATA: tick increments. At tick=15 (mid-bit), shift RxD in LSB-first (shift right, new bit into MSB) and tick=0. After the 8th bit -> STOP.
  - STOP: at tick=15, sample RxD. If 1: rec_buff <= shift register, RDA <= 1. If 0 (framing error): byte discarded, rec_buff and RDA unchanged. Either way -> IDLE.
- RDA clear: any clk cycle with IOCS=1, IORW=1, IOADDR=00 clears RDA; rec_buff holds its value.
- A byte completing in the same cycle as a read: set wins, RDA=1.
- Overrun: a new valid byte overwrites rec_buff; RDA stays 1; there is no overrun flag.
- Divisor writes during a frame take effect immediately; the frame in progress is not aborted.
- Reset mid-frame returns to IDLE and discards the partial byte.

Test Plan:
- Reset, then write 650 (IOADDR=10, baud_gen=8'h8A; IOADDR=11, baud_gen=8'h02; baud_load=1 one cycle each) -> rxEnable every 651 clocks, txEnable every 10416 clocks, each exactly 1 cycle wide.
- RxD frame start=0, data 1,0,1,0,1,0,1,0 LSB-first, stop=1, 104160 ns per bit -> after stop mid-sample: rec_buff=8'h55, RDA=1.
- Same frame with stop bit = 0 -> RDA stays 0, rec_buff unchanged (8'h00 after reset).
- RxD low pulse of 30 us (under half a bit) from idle -> FSM returns to IDLE, no RDA.
- Read after 8'h55 (IOCS=1, IORW=1, IOADDR=00, one cycle) -> RDA=0 next cycle, rec_buff=8'h55 held. Then receive 8'hA3 unread and 8'h0F -> rec_buff=8'h0F, RDA=1.
- Assert rst mid-frame -> all outputs at reset values immediately; next complete frame 8'hC6 is received correctly.

Source files
------------

// File: rtl/spart_rx_core_if.sv
// rtl/spart_rx_core_if.sv - processor-side register bus of the SPART receive core
interface spart_rx_core_if;
    logic       IOCS;
    logic       IORW;
    logic [1:0] IOADDR;
    logic       baud_load;
    logic [7:0] baud_gen;
    logic [7:0] rec_buff;
    logic       RDA;

    modport master (
        output IOCS, IORW, IOADDR, baud_load, baud_gen,
        input  rec_buff, RDA
    );

    modport slave (
        input  IOCS, IORW, IOADDR, baud_load, baud_gen,
        output rec_buff, RDA
    );
endinterface

// File: rtl/spart_rx_core.sv
// rtl/spart_rx_core.sv - SPART baud-rate generator and 8N1 UART receiver
module spart_rx_core #(
    parameter logic [15:0] RESET_DIVISOR = 16'd650,
    parameter int          DATA_BITS     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RxD,
    output logic               rxEnable,
    output logic               txEnable,
    spart_rx_core_if.slave     bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [15:0] divisor;
    logic [15:0] down_cnt;
    logic [3:0]  os_cnt;

    logic        rxd_meta;
    logic        rxd_sync;
    logic [1:0]  state;
    logic [3:0]  tick;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [7:0]  rec_q;
    logic        rda_q;
    logic        rd_clr;

    assign bus.rec_buff = rec_q;
    assign bus.RDA      = rda_q;
    assign rd_clr       = bus.IOCS && bus.IORW && (bus.IOADDR == 2'b00);

    // A divisor write restarts the count from the new full value so the
    // next tick reflects the new rate without waiting out the old period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor  <= RESET_DIVISOR;
            down_cnt <= RESET_DIVISOR;
            os_cnt   <= 4'd0;
            rxEnable <= 1'b0;
            txEnable <= 1'b0;
        end else begin
            rxEnable <= 1'b0;
            txEnable <= 1'b0;
            if (bus.baud_load && bus.IOADDR == 2'b10) begin
                divisor[7:0] <= bus.baud_gen;
                down_cnt     <= {divisor[15:8], bus.baud_gen};
            end else if (bus.baud_load && bus.IOADDR == 2'b11) begin
                divisor[15:8] <= bus.baud_gen;
                down_cnt      <= {bus.baud_gen, divisor[7:0]};
            end else if (down_cnt == 16'd0) begin
                rxEnable <= 1'b1;
                down_cnt <= divisor;
                os_cnt   <= os_cnt + 4'd1;
                if (os_cnt == 4'd15) begin
                    txEnable <= 1'b1;
                end
            end else begin
                down_cnt <= down_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            state     <= ST_IDLE;
            tick      <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rec_q     <= 8'h00;
            rda_q     <= 1'b0;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
            if (rd_clr) begin
                rda_q <= 1'b0;
            end
            // Completion below is written after the clear so a byte landing
            // on the same cycle as a read leaves RDA set.
            if (rxEnable) begin
                case (state)
                    ST_IDLE: begin
                        if (!rxd_sync) begin
                            state <= ST_START;
                            tick  <= 4'd0;
                        end
                    end
                    ST_START: begin
                        if (tick == 4'd7) begin
                            if (!rxd_sync) begin
                                state   <= ST_DATA;
                                tick    <= 4'd0;
                                bit_idx <= 3'd0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick == 4'd15) begin
                            shift_reg <= {rxd_sync, shift_reg[7:1]};
                            tick      <= 4'd0;
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == LAST_BIT) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    default: begin
                        if (tick == 4'd15) begin
                            if (rxd_sync) begin
                                rec_q <= shift_reg;
                                rda_q <= 1'b1;
                            end
                            state <= ST_IDLE;
                            tick  <= 4'd0;
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_rx_core.sv
// tb/tb_spart_rx_core.sv - self-checking bench for spart_rx_core
module tb_spart_rx_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RxD = 1'b1;
    logic rxEnable;
    logic txEnable;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   bit_clks = 16 * 4;

    typedef struct {
        logic [7:0] rec;
        logic       rda;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rec = 8'h00;
    logic       model_rda = 1'b0;

    spart_rx_core_if bus ();

    spart_rx_core dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .rxEnable (rxEnable),
        .txEnable (txEnable),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_div(input logic [1:0] addr, input logic [7:0] val);
        @(negedge clk);
        bus.baud_load = 1'b1;
        bus.IOADDR    = addr;
        bus.baud_gen  = val;
        @(negedge clk);
        bus.baud_load = 1'b0;
        bus.IOADDR    = 2'b00;
    endtask

    task automatic read_rx();
        @(negedge clk);
        bus.IOCS   = 1'b1;
        bus.IORW   = 1'b1;
        bus.IOADDR = 2'b00;
        @(negedge clk);
        bus.IOCS   = 1'b0;
        bus.IORW   = 1'b0;
        model_rda  = 1'b0;
    endtask

    task automatic wait_rx(output int t);
        t = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rxEnable) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("rx_timeout", 0, 1);
    endtask

    task automatic wait_tx(output int t);
        t = -1;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (txEnable) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("tx_timeout", 0, 1);
    endtask

    // Scoreboard entry is pushed as the frame is driven and compared once
    // the whole frame, including its stop bit, has gone by.
    task automatic send_frame(input string tag, input logic [7:0] data, input logic stop_bit);
        exp_t e;
        if (stop_bit) begin
            model_rec = data;
            model_rda = 1'b1;
        end
        e.rec = model_rec;
        e.rda = model_rda;
        sb.push_back(e);
        @(negedge clk);
        RxD = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (bit_clks) @(negedge clk);
        RxD = 1'b1;
        e = sb.pop_front();
        check({tag, "_rec"}, bus.rec_buff, e.rec);
        check({tag, "_rda"}, bus.RDA, e.rda);
        repeat (2 * bit_clks) @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        bus.IOCS      = 1'b0;
        bus.IORW      = 1'b0;
        bus.IOADDR    = 2'b00;
        bus.baud_load = 1'b0;
        bus.baud_gen  = 8'h00;

        #1;
        check("rst_rec", bus.rec_buff, 8'h00);
        check("rst_rda", bus.RDA, 0);
        check("rst_rxen", rxEnable, 0);
        check("rst_txen", txEnable, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        write_div(2'b10, 8'h8A);
        write_div(2'b11, 8'h02);
        wait_rx(t0);
        @(negedge clk);
        check("rx_width", rxEnable, 0);
        wait_rx(t1);
        check("rx_period", t1 - t0, 651);
        wait_tx(t0);
        check("tx_with_rx", rxEnable, 1);
        @(negedge clk);
        check("tx_width", txEnable, 0);
        wait_tx(t1);
        check("tx_period", t1 - t0, 10416);

        write_div(2'b10, 8'h00);
        write_div(2'b11, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("div0_rxen", rxEnable, 1);
        end

        write_div(2'b10, 8'h03);
        write_div(2'b11, 8'h00);
        wait_rx(t0);
        wait_rx(t1);
        check("div3_period", t1 - t0, 4);
        repeat (2 * bit_clks) @(negedge clk);

        send_frame("frame_err", 8'h55, 1'b0);

        @(negedge clk);
        RxD = 1'b0;
        repeat (18) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * bit_clks) @(negedge clk);
        check("glitch_rda", bus.RDA, 0);
        check("glitch_rec", bus.rec_buff, 8'h00);

        send_frame("rx55", 8'h55, 1'b1);

        read_rx();
        check("read_rda", bus.RDA, model_rda);
        check("read_rec", bus.rec_buff, 8'h55);

        send_frame("rxA3", 8'hA3, 1'b1);
        send_frame("rx0F", 8'h0F, 1'b1);

        @(negedge clk);
        RxD = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = i[0];
            repeat (bit_clks) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_rec", bus.rec_buff, 8'h00);
        check("mid_rst_rda", bus.RDA, 0);
        check("mid_rst_rxen", rxEnable, 0);
        model_rec = 8'h00;
        model_rda = 1'b0;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        write_div(2'b10, 8'h03);
        write_div(2'b11, 8'h00);
        repeat (2 * bit_clks) @(negedge clk);

        send_frame("rxC6", 8'hC6, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
